// File: rtl/rom_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Hack CPU instruction ROM with a serial, checksummed program
//            loader. Bytes arrive from a UART receiver as a frame
//            (AA, LEN_HI, LEN_LO, N x {HI, LO}, XOR checksum). The frame's
//            words are written into the ROM. The CPU is held in reset until
//            a complete frame with a valid checksum has been loaded.
// Ports    : clk, reset       - clock and synchronous active-high reset
//            rx_data/rx_valid - received byte and its single-cycle strobe
//            pc               - fetch address from the CPU
//            instruction      - registered rom[pc]
//            cpu_reset        - reset for the CPU, low only in RUN
//            loading          - a frame is in progress
//            load_ok/load_err - result of the last completed frame
//            words_loaded     - words written by the current or last frame
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           instruction,
    output logic                  cpu_reset,
    output logic                  loading,
    output logic                  load_ok,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;

    logic [2:0]            state_q,  state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   n_q,      n_d;
    logic [ADDR_WIDTH:0]   cnt_q,    cnt_d;
    logic [7:0]            hi_q,     hi_d;
    logic [7:0]            csum_q,   csum_d;
    logic                  ok_q,     ok_d;
    logic                  err_q,    err_d;
    logic [15:0]           instr_q;
    logic                  wr_en;

    logic [15:0]           mem_q [DEPTH];

    // Length is widened to 32 bits so the upper-bound compare against the
    // ROM depth sees every bit of the 16-bit field regardless of ADDR_WIDTH.
    logic [31:0]           len_ext;
    logic                  len_bad;
    logic [ADDR_WIDTH:0]   cnt_inc;

    assign len_ext = {16'd0, len_hi_q, rx_data};
    assign len_bad = (len_ext == 32'd0) || (len_ext > (32'd1 << ADDR_WIDTH));
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        csum_d   = csum_q;
        ok_d     = ok_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (rx_data == 8'hAA) begin
                        state_d = S_LEN_HI;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        csum_d  = 8'h00;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (len_bad) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        n_d     = len_ext[ADDR_WIDTH:0];
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt_inc;
                    csum_d  = csum_q ^ rx_data;
                    state_d = (cnt_inc == n_q) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (rx_data == csum_q) begin
                        state_d = S_RUN;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_hi_q <= 8'h00;
            n_q      <= '0;
            cnt_q    <= '0;
            hi_q     <= 8'h00;
            csum_q   <= 8'h00;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            csum_q   <= csum_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    // The word counter doubles as the write address: it never exceeds N-1
    // while writing, and N is bounded by the ROM depth, so it cannot wrap.
    // ROM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cnt_q[ADDR_WIDTH-1:0]] <= {hi_q, rx_data};
        end
    end

    // Read port is independent of the write port; a same-address collision
    // returns the previous contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 16'h0000;
        end else begin
            instr_q <= mem_q[pc];
        end
    end

    assign instruction  = instr_q;
    assign cpu_reset    = (state_q != S_RUN);
    assign loading      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                          (state_q == S_CHECK);
    assign load_ok      = ok_q;
    assign load_err     = err_q;
    assign words_loaded = cnt_q;

endmodule
`default_nettype wire
